// File: rtl/bus_initiator_pkg.sv
// Shared bus constants, error codes and FSM state type for the bus initiator.
// These are the values that would otherwise come from the core-wide bus header.
package bus_initiator_pkg;

   localparam int BUS_WIDTH     = 32;
   localparam int BUS_ACC_WIDTH = 2;

   localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
   localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

   typedef logic [1:0] bus_err_t;
   localparam bus_err_t BUS_ERR_OK      = 2'd0;
   localparam bus_err_t BUS_ERR_FAULT   = 2'd1;
   localparam bus_err_t BUS_ERR_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Command/response handshake plus peripheral bus signals of the bus initiator.
// master = initiator side, slave = requester + responder side.
interface bus_initiator_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                                         cmd_valid;
   logic                                         cmd_ready;
   logic                                         cmd_w_rb;
   logic [ADDR_WIDTH-1:0]                        cmd_addr;
   logic [bus_initiator_pkg::BUS_ACC_WIDTH-1:0]  cmd_acc;
   logic [bus_initiator_pkg::BUS_WIDTH-1:0]      cmd_wdata;

   logic                                         rsp_valid;
   logic [1:0]                                   rsp_err;
   logic [bus_initiator_pkg::BUS_WIDTH-1:0]      rsp_rdata;

   logic [ADDR_WIDTH-1:0]                        addr;
   logic                                         w_rb;
   logic [bus_initiator_pkg::BUS_ACC_WIDTH-1:0]  acc;
   logic [bus_initiator_pkg::BUS_WIDTH-1:0]      wdata;
   logic                                         req;
   logic [bus_initiator_pkg::BUS_WIDTH-1:0]      rdata;
   logic                                         resp;
   logic                                         fault;

   modport master (
      input  cmd_valid, cmd_w_rb, cmd_addr, cmd_acc, cmd_wdata,
      input  rdata, resp, fault,
      output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
      output addr, w_rb, acc, wdata, req
   );

   modport slave (
      output cmd_valid, cmd_w_rb, cmd_addr, cmd_acc, cmd_wdata,
      output rdata, resp, fault,
      input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
      input  addr, w_rb, acc, wdata, req
   );

endinterface

// File: rtl/bus_initiator_timeout_counter.sv
// WAIT-cycle counter: cleared outside WAIT, counts each silent WAIT cycle,
// flags expiry on the cycle that would be the TIMEOUT-th one without a resp.
module bus_initiator_timeout_counter #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding peripheral bus initiator: one command in, one req pulse out,
// then a registered completion carrying OK / FAULT / TIMEOUT and read data.
module bus_initiator
   import bus_initiator_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int TO_W       = 8
) (
   input  logic             clk,
   input  logic             rstn,
   bus_initiator_if.master  bif
);

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic                     w_rb_q, w_rb_d;
   logic [BUS_ACC_WIDTH-1:0] acc_q, acc_d;
   logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
   logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
   bus_err_t                 err_q, err_d;

   logic cnt_clr;
   logic cnt_en;
   logic cnt_expired;

   bus_initiator_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .expired (cnt_expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      w_rb_d  = w_rb_q;
      acc_d   = acc_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (bif.cmd_valid) begin
               addr_d  = bif.cmd_addr;
               w_rb_d  = bif.cmd_w_rb;
               acc_d   = bif.cmd_acc;
               wdata_d = bif.cmd_wdata;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // fault is only meaningful in the req cycle; it outranks a same-cycle resp
            cnt_clr = 1'b1;
            if (bif.fault) begin
               err_d   = BUS_ERR_FAULT;
               state_d = ST_DONE;
            end else if (bif.resp) begin
               err_d   = BUS_ERR_OK;
               if (!w_rb_q) begin
                  rdata_d = bif.rdata;
               end
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bif.resp) begin
               err_d   = BUS_ERR_OK;
               if (!w_rb_q) begin
                  rdata_d = bif.rdata;
               end
               state_d = ST_DONE;
            end else if (cnt_expired) begin
               err_d   = BUS_ERR_TIMEOUT;
               state_d = ST_DONE;
            end else begin
               cnt_en  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         w_rb_q  <= 1'b0;
         acc_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= BUS_ERR_OK;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         w_rb_q  <= w_rb_d;
         acc_q   <= acc_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // req and rsp_valid decode straight from the state flop so each is a clean one-cycle pulse
   assign bif.req       = (state_q == ST_ISSUE);
   assign bif.rsp_valid = (state_q == ST_DONE);
   assign bif.cmd_ready = rstn && (state_q == ST_IDLE);
   assign bif.rsp_err   = err_q;
   assign bif.rsp_rdata = rdata_q;
   assign bif.addr      = addr_q;
   assign bif.w_rb      = w_rb_q;
   assign bif.acc       = acc_q;
   assign bif.wdata     = wdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboard bench for bus_initiator: behavioural responder, expected completions
// queued when a command is driven and compared when rsp_valid pulses.
module tb_bus_initiator;
   import bus_initiator_pkg::*;

   localparam int TO = 8;

   typedef struct packed {
      logic [1:0]  err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bus_initiator_if #(.ADDR_WIDTH(32)) bif ();

   bus_initiator #(
      .ADDR_WIDTH (32),
      .TIMEOUT    (TO),
      .TO_W       (8)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bif  (bif)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   exp_t exp_q[$];
   logic [31:0] model_rdata = '0;

   // responder control, set by the driver before each command
   int          rsp_delay = -1;
   bit          rsp_fault = 1'b0;
   logic [31:0] rsp_data = '0;

   int          req_cnt = 0;
   int          rsp_cnt = 0;
   int          last_req_cyc = 0;
   int          last_rsp_cyc = 0;
   int          accept_cyc = 0;
   logic [31:0] seen_addr = '0;
   logic [31:0] seen_wdata = '0;
   logic [1:0]  seen_acc = '0;
   logic        seen_w_rb = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // responder: fault is combinational in the req cycle, resp arrives rsp_delay cycles after req
   initial begin
      int cd;
      bit prev_req;
      cd = -1;
      prev_req = 1'b0;
      bif.resp = 1'b0;
      bif.fault = 1'b0;
      bif.rdata = '0;
      forever begin
         @(negedge clk);
         bif.resp = 1'b0;
         bif.fault = 1'b0;
         if (!rstn) begin
            cd = -1;
            prev_req = 1'b0;
         end else begin
            if (bif.req) begin
               check_eq("req_one_cycle", prev_req, 1'b0);
               req_cnt++;
               last_req_cyc = cyc;
               seen_addr = bif.addr;
               seen_wdata = bif.wdata;
               seen_acc = bif.acc;
               seen_w_rb = bif.w_rb;
               cd = -1;
               if (rsp_fault) begin
                  bif.fault = 1'b1;
                  bif.rdata = ~rsp_data;
               end else if (rsp_delay == 0) begin
                  bif.resp = 1'b1;
                  bif.rdata = rsp_data;
               end else if (rsp_delay > 0) begin
                  cd = rsp_delay;
               end
            end else if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  bif.resp = 1'b1;
                  bif.rdata = rsp_data;
                  cd = -1;
               end
            end
            prev_req = bif.req;
         end
      end
   end

   // completion monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && bif.rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            check_eq("rsp_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("rsp_err", bif.rsp_err, e.err);
               check_eq("rsp_rdata", bif.rsp_rdata, e.rdata);
               $display("rsp %0d cycle %0d err=%0d rdata=%08h (exp err=%0d rdata=%08h)",
                        rsp_cnt, cyc, bif.rsp_err, bif.rsp_rdata, e.err, e.rdata);
            end
         end
      end
   end

   // called on a negedge; leaves cmd_valid high on return (DUT is then in ISSUE)
   task automatic send(input bit w, input logic [31:0] a, input logic [1:0] ac,
                       input logic [31:0] wd, input int dly, input bit flt,
                       input logic [31:0] rd, input logic [1:0] exp_err);
      exp_t e;
      int n;
      n = 0;
      while (!bif.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("cmd_ready_wait", bif.cmd_ready, 1'b1);
      rsp_delay = dly;
      rsp_fault = flt;
      rsp_data = rd;
      bif.cmd_valid = 1'b1;
      bif.cmd_w_rb = w;
      bif.cmd_addr = a;
      bif.cmd_acc = ac;
      bif.cmd_wdata = wd;
      if (exp_err == BUS_ERR_OK && !w) model_rdata = rd;
      e.err = exp_err;
      e.rdata = model_rdata;
      exp_q.push_back(e);
      accept_cyc = cyc;
      $display("cmd cycle %0d w_rb=%0b addr=%08h acc=%0d wdata=%08h dly=%0d fault=%0b",
               cyc, w, a, ac, wd, dly, flt);
      @(negedge clk);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("rsp_wait", exp_q.size(), 0);
   endtask

   initial begin
      int r0;
      int c0;
      int acc_cyc[3];
      bif.cmd_valid = 1'b0;
      bif.cmd_w_rb = 1'b0;
      bif.cmd_addr = '0;
      bif.cmd_acc = '0;
      bif.cmd_wdata = '0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_req", bif.req, 1'b0);
      check_eq("rst_rsp_valid", bif.rsp_valid, 1'b0);
      check_eq("rst_rsp_err", bif.rsp_err, BUS_ERR_OK);
      check_eq("rst_rsp_rdata", bif.rsp_rdata, 0);
      check_eq("rst_addr", bif.addr, 0);
      check_eq("rst_wdata", bif.wdata, 0);
      check_eq("rst_w_rb", bif.w_rb, 1'b0);
      check_eq("rst_acc", bif.acc, 0);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", bif.cmd_ready, 1'b1);

      // registered responder read: accept c0, req c1, resp c2, rsp c3
      r0 = req_cnt;
      send(1'b0, 32'h0000_0010, BUS_ACC_4B, 32'h0, 1, 1'b0, 32'h0000_0005, BUS_ERR_OK);
      bif.cmd_valid = 1'b0;
      wait_done();
      check_eq("rd_req_count", req_cnt - r0, 1);
      check_eq("rd_latency", last_rsp_cyc - accept_cyc, 3);
      check_eq("rd_bus_addr", seen_addr, 32'h0000_0010);
      check_eq("rd_bus_w_rb", seen_w_rb, 1'b0);
      check_eq("rd_bus_acc", seen_acc, BUS_ACC_4B);

      // write rejected with fault in the req cycle: straight to DONE, rdata held
      send(1'b1, 32'h2000_0004, BUS_ACC_1B, 32'hDEAD_BEEF, 0, 1'b1, 32'h1111_2222, BUS_ERR_FAULT);
      bif.cmd_valid = 1'b0;
      wait_done();
      check_eq("fault_latency", last_rsp_cyc - accept_cyc, 2);
      check_eq("wr_bus_wdata", seen_wdata, 32'hDEAD_BEEF);
      check_eq("wr_bus_w_rb", seen_w_rb, 1'b1);
      check_eq("wr_bus_acc", seen_acc, BUS_ACC_1B);

      // zero-wait responder read
      send(1'b0, 32'h0000_0014, BUS_ACC_4B, 32'h0, 0, 1'b0, 32'h0000_0077, BUS_ERR_OK);
      bif.cmd_valid = 1'b0;
      wait_done();
      check_eq("zw_latency", last_rsp_cyc - accept_cyc, 2);

      // silent responder: TIMEOUT after exactly TO WAIT cycles
      send(1'b0, 32'h0000_0018, BUS_ACC_4B, 32'h0, -1, 1'b0, 32'hBAD0_0000, BUS_ERR_TIMEOUT);
      bif.cmd_valid = 1'b0;
      wait_done();
      check_eq("to_wait_cycles", last_rsp_cyc - last_req_cyc - 1, TO);

      // resp on the expiry cycle wins over timeout
      send(1'b0, 32'h0000_001C, BUS_ACC_4B, 32'h0, TO, 1'b0, 32'h0000_1234, BUS_ERR_OK);
      bif.cmd_valid = 1'b0;
      wait_done();
      check_eq("edge_resp_latency", last_rsp_cyc - last_req_cyc, TO + 1);

      // timeout, then the late resp lands in IDLE and must be ignored
      c0 = rsp_cnt;
      send(1'b0, 32'h0000_0020, BUS_ACC_4B, 32'h0, TO + 2, 1'b0, 32'h9999_9999, BUS_ERR_TIMEOUT);
      bif.cmd_valid = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);
      check_eq("late_resp_rsp_count", rsp_cnt - c0, 1);
      check_eq("late_resp_ready", bif.cmd_ready, 1'b1);
      check_eq("late_resp_rdata_held", bif.rsp_rdata, model_rdata);

      // cmd_valid held high for three commands: one accept every 4 cycles
      r0 = req_cnt;
      send(1'b1, 32'h0000_0100, BUS_ACC_4B, 32'hA000_0001, 1, 1'b0, 32'h0, BUS_ERR_OK);
      acc_cyc[0] = accept_cyc;
      send(1'b0, 32'h0000_0104, BUS_ACC_4B, 32'h0, 1, 1'b0, 32'h0000_00B1, BUS_ERR_OK);
      acc_cyc[1] = accept_cyc;
      send(1'b0, 32'h0000_0108, BUS_ACC_4B, 32'h0, 1, 1'b0, 32'h0000_00C2, BUS_ERR_OK);
      acc_cyc[2] = accept_cyc;
      bif.cmd_valid = 1'b0;
      wait_done();
      check_eq("b2b_gap0", acc_cyc[1] - acc_cyc[0], 4);
      check_eq("b2b_gap1", acc_cyc[2] - acc_cyc[1], 4);
      check_eq("b2b_req_count", req_cnt - r0, 3);

      // reset while in WAIT aborts silently; the next command completes normally
      c0 = rsp_cnt;
      send(1'b0, 32'h0000_0200, BUS_ACC_4B, 32'h0, -1, 1'b0, 32'h0, BUS_ERR_TIMEOUT);
      bif.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      check_eq("mid_rst_req", bif.req, 1'b0);
      check_eq("mid_rst_rsp_valid", bif.rsp_valid, 1'b0);
      check_eq("mid_rst_addr", bif.addr, 0);
      check_eq("mid_rst_rdata", bif.rsp_rdata, 0);
      exp_q.delete();
      model_rdata = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_no_rsp", rsp_cnt - c0, 0);
      send(1'b0, 32'h0000_0300, BUS_ACC_4B, 32'h0, 2, 1'b0, 32'hA5A5_0001, BUS_ERR_OK);
      bif.cmd_valid = 1'b0;
      wait_done();
      check_eq("post_rst_latency", last_rsp_cyc - accept_cyc, 4);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
